// File: rtl/hwpe_vop_engine_pkg.sv
// -----------------------------------------------------------------------------
// hwpe_ctrl_vfpu_package
// Shared types for the VFPU vector-operation engine.
//   vop_mode_e  : element-wise operation selected per job (ADD..XOR)
//   vop_state_e : job sequencing states of the engine controller
// -----------------------------------------------------------------------------
package hwpe_ctrl_vfpu_package;

    typedef enum logic [2:0] {
        VOP_ADD = 3'd0,
        VOP_SUB = 3'd1,
        VOP_MUL = 3'd2,
        VOP_MIN = 3'd3,
        VOP_MAX = 3'd4,
        VOP_AND = 3'd5,
        VOP_OR  = 3'd6,
        VOP_XOR = 3'd7
    } vop_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } vop_state_e;

endpackage

// File: rtl/hwpe_vop_engine_if.sv
// -----------------------------------------------------------------------------
// hwpe_vop_engine_if
// Operand/result stream bundle of the vector-operation engine. Signal names
// keep the engine-relative _i/_o suffixes used by the surrounding HWPE.
//   op_valid_i  : per-stream valid, one bit per operand stream
//   op_data_i   : packed operand words, stream k at [k*DATA_WIDTH +: DATA_WIDTH]
//   op_ready_o  : common ready, all streams accept together
//   res_valid_o : result valid
//   res_data_o  : result word
//   res_ready_i : sink ready
// Modports: slave = engine side, master = source/sink side.
// -----------------------------------------------------------------------------
interface hwpe_vop_engine_if #(
    parameter int NB_OPERANDS = 2,
    parameter int DATA_WIDTH  = 32
);
    logic [NB_OPERANDS-1:0]            op_valid_i;
    logic [NB_OPERANDS*DATA_WIDTH-1:0] op_data_i;
    logic                              op_ready_o;
    logic                              res_valid_o;
    logic [DATA_WIDTH-1:0]             res_data_o;
    logic                              res_ready_i;

    modport slave (
        input  op_valid_i, op_data_i, res_ready_i,
        output op_ready_o, res_valid_o, res_data_o
    );

    modport master (
        output op_valid_i, op_data_i, res_ready_i,
        input  op_ready_o, res_valid_o, res_data_o
    );
endinterface

// File: rtl/hwpe_vop_alu.sv
// -----------------------------------------------------------------------------
// hwpe_vop_alu
// Combinational N-operand fold: result = (((op0 f op1) f op2) ...) for the
// selected mode, truncated to DATA_WIDTH. MIN/MAX compare as signed.
//   mode     : operation (vop_mode_e)
//   operands : packed operands, operand k at [k*DATA_WIDTH +: DATA_WIDTH]
//   result   : folded result
// -----------------------------------------------------------------------------
module hwpe_vop_alu
    import hwpe_ctrl_vfpu_package::*;
#(
    parameter int NB_OPERANDS = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  vop_mode_e                         mode,
    input  logic [NB_OPERANDS*DATA_WIDTH-1:0] operands,
    output logic [DATA_WIDTH-1:0]             result
);

    always_comb begin
        logic [DATA_WIDTH-1:0] acc;
        logic [DATA_WIDTH-1:0] rhs;
        // NOTE: every variable gets a value before any branch, so no path
        // through this block can leave one unassigned and infer a latch.
        acc = operands[DATA_WIDTH-1:0];
        rhs = '0;
        for (int i = 1; i < NB_OPERANDS; i++) begin
            rhs = operands[i*DATA_WIDTH +: DATA_WIDTH];
            case (mode)
                VOP_ADD: acc = acc + rhs;
                VOP_SUB: acc = acc - rhs;
                VOP_MUL: acc = acc * rhs;
                VOP_MIN: acc = ($signed(rhs) < $signed(acc)) ? rhs : acc;
                VOP_MAX: acc = ($signed(rhs) > $signed(acc)) ? rhs : acc;
                VOP_AND: acc = acc & rhs;
                VOP_OR:  acc = acc | rhs;
                VOP_XOR: acc = acc ^ rhs;
                default: acc = acc;
            endcase
        end
        result = acc;
    end

endmodule

// File: rtl/hwpe_vop_engine.sv
// -----------------------------------------------------------------------------
// hwpe_vop_engine
// Streaming vector-operation engine: joins NB_OPERANDS element streams, folds
// each element through hwpe_vop_alu and a PIPE_STAGES-deep stallable pipeline,
// and emits one result per element or, in accumulate mode, one wrapped sum of
// all element results per job.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : synchronous flush to IDLE (discards results in flight)
//   start_i      : job start pulse, honoured in IDLE only
//   mode_i       : operation, sampled at start
//   acc_en_i     : accumulate mode, sampled at start
//   len_i        : element count, sampled at start
//   stream       : operand/result streams (hwpe_vop_engine_if.slave)
//   busy_o       : controller not in IDLE
//   done_o       : one-cycle job-complete pulse
//   out_cnt_o    : results handed off in the current job
// -----------------------------------------------------------------------------
module hwpe_vop_engine
    import hwpe_ctrl_vfpu_package::*;
#(
    parameter int NB_OPERANDS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [2:0]           mode_i,
    input  logic                 acc_en_i,
    input  logic [CNT_WIDTH-1:0] len_i,
    hwpe_vop_engine_if.slave     stream,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] out_cnt_o
);

    localparam int LAST = PIPE_STAGES - 1;

    vop_state_e             state_q, state_d;
    vop_mode_e              mode_q;
    logic                   acc_en_q;
    logic [CNT_WIDTH-1:0]   len_q;
    logic [CNT_WIDTH-1:0]   in_cnt_q;
    logic [CNT_WIDTH-1:0]   out_cnt_q;
    logic [PIPE_STAGES-1:0] stage_valid_q;
    logic [DATA_WIDTH-1:0]  stage_data_q [PIPE_STAGES];
    logic [DATA_WIDTH-1:0]  acc_q;
    logic                   acc_valid_q;

    logic [DATA_WIDTH-1:0]  alu_res;
    logic                   start_ok;
    logic                   adv;
    logic                   accept;
    logic                   last_in;
    logic                   upstream_valid;
    logic                   leave;
    logic                   final_leave;
    logic                   res_valid;
    logic                   res_hs;
    logic                   last_hs;

    hwpe_vop_alu #(
        .NB_OPERANDS (NB_OPERANDS),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_alu (
        .mode     (mode_q),
        .operands (stream.op_data_i),
        .result   (alu_res)
    );

    // Any stage other than the last still holding an element.
    always_comb begin
        upstream_valid = 1'b0;
        for (int i = 0; i < LAST; i++) begin
            upstream_valid = upstream_valid | stage_valid_q[i];
        end
    end

    // The whole pipe moves only when the output slot is empty or being taken.
    assign adv      = !stage_valid_q[LAST] || stream.res_ready_i;
    assign start_ok = (state_q == IDLE) && start_i;
    assign last_in  = (in_cnt_q == len_q - CNT_WIDTH'(1));
    assign accept   = stream.op_ready_o && (&stream.op_valid_i);

    // An element leaving the last stage; in DRAIN with nothing behind it,
    // it is the final element of the job.
    assign leave       = stage_valid_q[LAST] && adv;
    assign final_leave = (state_q == DRAIN) && leave && !upstream_valid;

    // Accumulate mode hides the per-element results behind the sum register.
    assign res_valid = acc_en_q ? acc_valid_q : stage_valid_q[LAST];
    assign res_hs    = res_valid && stream.res_ready_i;
    assign last_hs   = (state_q == DRAIN) && res_hs && (acc_en_q || !upstream_valid);

    assign stream.op_ready_o  = (state_q == RUN) && (in_cnt_q < len_q) && adv;
    assign stream.res_valid_o = res_valid;
    assign stream.res_data_o  = acc_en_q ? acc_q : stage_data_q[LAST];

    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign out_cnt_o = out_cnt_q;

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = (len_i == '0) ? DONE : RUN;
                RUN:     if (accept && last_in) state_d = DRAIN;
                DRAIN:   if (last_hs) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state elements use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Job parameters, counters and the accumulator.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q      <= VOP_ADD;
            acc_en_q    <= 1'b0;
            len_q       <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
        end else if (clear_i) begin
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
        end else if (start_ok) begin
            mode_q      <= vop_mode_e'(mode_i);
            acc_en_q    <= acc_en_i;
            len_q       <= len_i;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            if (accept) in_cnt_q  <= in_cnt_q + CNT_WIDTH'(1);
            if (res_hs) out_cnt_q <= out_cnt_q + CNT_WIDTH'(1);
            if (acc_en_q && leave) acc_q <= acc_q + stage_data_q[LAST];
            // The sum is complete on the edge the final element leaves.
            if (acc_en_q && final_leave) acc_valid_q <= 1'b1;
            else if (res_hs)             acc_valid_q <= 1'b0;
        end
    end

    // Stallable pipeline; stage 0 registers the ALU output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_valid_q <= '0;
            // NOTE: the stage data words are reset too, so res_data_o reads 0
            // during and after reset; a deep data buffer would skip this.
            for (int i = 0; i < PIPE_STAGES; i++) stage_data_q[i] <= '0;
        end else if (clear_i) begin
            stage_valid_q <= '0;
        end else if (adv) begin
            stage_valid_q[0] <= accept;
            stage_data_q[0]  <= alu_res;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                stage_valid_q[i] <= stage_valid_q[i-1];
                stage_data_q[i]  <= stage_data_q[i-1];
            end
        end
    end

endmodule
